// File: rtl/mem_probe_stepper.sv
// Debug probe that walks a synchronous memory read port one word at a time.
// Steps come from debounced next/prev buttons or from an auto-scan timer.
module mem_probe_stepper #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 1024,
  parameter int RD_LAT   = 1,
  parameter int DEB_CYC  = 1000000,
  parameter int SCAN_PER = 50000000,
  parameter int BLANK    = 1
) (
  input  logic              clk100mhz,
  input  logic              rst,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              auto_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy,
  output logic              out_valid
);

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int SCAN_W = $clog2(SCAN_PER + 1);
  localparam int LAT_W  = $clog2(RD_LAT + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PER - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Bit 0 is the next button, bit 1 the prev button.
  logic [1:0]       btn_raw;
  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       deb;
  logic [1:0]       deb_d;
  logic [1:0]       btn_pulse;
  logic [DEB_W-1:0] deb_cnt [2];

  logic [SCAN_W-1:0] scan_cnt;
  logic              auto_pulse;

  logic              want_next;
  logic              want_prev;
  logic              step_ok;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_dec;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [LAT_W-1:0]  lat_cnt;
  logic [LAT_W-1:0]  lat_n;
  logic              capture;
  logic [DATA_W-1:0] data_q;

  assign btn_raw = {btn_prev, btn_next};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      // NOTE: this is a two-entry register array, not a RAM, so it is reset
      // like any other flop; a real memory array would be left unreset.
      for (int b = 0; b < 2; b++) deb_cnt[b] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == deb[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DEB_LAST) begin
          deb[b]     <= sync2[b];
          deb_cnt[b] <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
        end
      end
    end
  end

  assign btn_pulse = deb & ~deb_d;

  always_ff @(posedge clk100mhz) begin
    if (rst || !auto_en) begin
      scan_cnt <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  assign auto_pulse = auto_en && (scan_cnt == SCAN_LAST);

  // Opposing requests in the same cycle cancel out.
  assign want_next = btn_pulse[0] | auto_pulse;
  assign want_prev = btn_pulse[1];
  assign step_ok   = want_next ^ want_prev;
  assign addr_inc  = (cur_addr == ADDR_LAST) ? '0 : cur_addr + ADDR_W'(1);
  assign addr_dec  = (cur_addr == '0) ? ADDR_LAST : cur_addr - ADDR_W'(1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    addr_n  = cur_addr;
    lat_n   = lat_cnt;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (step_ok) begin
          addr_n  = want_next ? addr_inc : addr_dec;
          state_n = ISSUE;
        end
      end
      // Reset lands here with the strobe low, so ISSUE holds one extra cycle
      // until the registered strobe has actually been driven.
      ISSUE: begin
        if (mem_rd_en) begin
          state_n = WAIT;
          lat_n   = LAT_W'(1);
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          capture = 1'b1;
          state_n = IDLE;
        end else begin
          lat_n = lat_cnt + LAT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk100mhz) begin
    if (rst) begin
      state     <= ISSUE;
      cur_addr  <= '0;
      lat_cnt   <= '0;
      mem_rd_en <= 1'b0;
      out_valid <= 1'b0;
      data_q    <= '0;
    end else begin
      state     <= state_n;
      cur_addr  <= addr_n;
      lat_cnt   <= lat_n;
      mem_rd_en <= (state_n == ISSUE);
      out_valid <= capture;
      if (capture) data_q <= mem_rdata;
    end
  end

  assign mem_addr = cur_addr;
  assign busy     = (state != IDLE);
  assign out      = ((BLANK != 0) && deb[0]) ? '0 : data_q;

endmodule
